// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: drives a 2-input gate through 00,01,10,11, samples y at the
// end of each hold window and reports a per-vector error mask and pass flag.
`default_nettype none

module gate_tt_sequencer #(
   parameter int         HOLD_CYCLES = 10,
   parameter logic [3:0] EXP_TT      = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask
);

   localparam logic [1:0] C_IDLE     = 2'd0;
   localparam logic [1:0] C_APPLY    = 2'd1;
   localparam logic [1:0] C_DONE     = 2'd2;
   localparam logic [7:0] C_LAST_CNT = 8'(HOLD_CYCLES - 1);

   generate
      if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_hold_check
         $error("gate_tt_sequencer: HOLD_CYCLES=%0d outside 2..255", HOLD_CYCLES);
      end
   endgenerate

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [1:0] w_vec_nxt;
   logic [3:0] w_mask_nxt;
   logic       w_a_nxt;
   logic       w_b_nxt;
   logic       w_busy_nxt;
   logic       w_done_nxt;
   logic       w_pass_nxt;
   logic       w_sample;

   assign w_sample = (r_state == C_APPLY) && (r_cnt == C_LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_IDLE:  if (start) w_state_nxt = C_APPLY;
         C_APPLY: if (w_sample && vec_idx == 2'd3) w_state_nxt = C_DONE;
         C_DONE:  if (start) w_state_nxt = C_APPLY;
         default: w_state_nxt = C_IDLE;
      endcase
   end

   // Next values of the registered outputs; everything is flopped below so
   // neither y nor start has a combinational path to any output.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_vec_nxt  = vec_idx;
      w_mask_nxt = err_mask;
      w_a_nxt    = a;
      w_b_nxt    = b;
      w_busy_nxt = busy;
      w_done_nxt = done;
      w_pass_nxt = pass;
      case (r_state)
         C_IDLE, C_DONE: begin
            if (start) begin
               w_cnt_nxt  = 8'd0;
               w_vec_nxt  = 2'd0;
               w_mask_nxt = 4'b0000;
               w_a_nxt    = 1'b0;
               w_b_nxt    = 1'b0;
               w_busy_nxt = 1'b1;
               w_done_nxt = 1'b0;
               w_pass_nxt = 1'b0;
            end
         end
         C_APPLY: begin
            if (w_sample) begin
               w_mask_nxt[vec_idx] = (y != EXP_TT[vec_idx]);
               w_cnt_nxt           = 8'd0;
               if (vec_idx == 2'd3) begin
                  w_vec_nxt  = 2'd0;
                  w_a_nxt    = 1'b0;
                  w_b_nxt    = 1'b0;
                  w_busy_nxt = 1'b0;
                  w_done_nxt = 1'b1;
                  w_pass_nxt = ~|w_mask_nxt;
               end else begin
                  w_vec_nxt          = vec_idx + 2'd1;
                  {w_a_nxt, w_b_nxt} = vec_idx + 2'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_cnt_nxt  = 8'd0;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 8'd0;
         vec_idx  <= 2'd0;
         err_mask <= 4'b0000;
         a        <= 1'b0;
         b        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         vec_idx  <= w_vec_nxt;
         err_mask <= w_mask_nxt;
         a        <= w_a_nxt;
         b        <= w_b_nxt;
         busy     <= w_busy_nxt;
         done     <= w_done_nxt;
         pass     <= w_pass_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: directed checks of gate_tt_sequencer with HOLD_CYCLES=10
// (behavioural gate models) and HOLD_CYCLES=2 (bench-driven y per cycle).
`default_nettype none

module tb_gate_tt_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       y;
   logic       y2 = 1'b0;
   logic [1:0] gate_sel = 2'd0;

   logic       a, b, busy, done, pass;
   logic [1:0] vec_idx;
   logic [3:0] err_mask;
   logic       a2, b2, busy2, done2, pass2;
   logic [1:0] vec2;
   logic [3:0] mask2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gate_tt_sequencer #(.HOLD_CYCLES(10), .EXP_TT(4'b0111)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y),
      .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
      .pass(pass), .err_mask(err_mask)
   );

   gate_tt_sequencer #(.HOLD_CYCLES(2), .EXP_TT(4'b0111)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
      .a(a2), .b(b2), .vec_idx(vec2), .busy(busy2), .done(done2),
      .pass(pass2), .err_mask(mask2)
   );

   // 0: NAND, 1: AND, 2: NAND with y stuck at 1 on {a,b}=11
   always_comb begin
      case (gate_sel)
         2'd1:    y = a & b;
         2'd2:    y = 1'b1;
         default: y = ~(a & b);
      endcase
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at the negedge just after the accepting edge; leaves one
   // negedge after the final sampling edge.
   task automatic sweep(input string tag, input logic [3:0] exp_mask,
                        input logic exp_pass, input bit repulse);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc % 10 == 0) begin
            check_val({tag, " ab"}, {6'd0, a, b}, 8'(cyc / 10));
            check_val({tag, " vec_idx"}, {6'd0, vec_idx}, 8'(cyc / 10));
         end
         if (cyc == 0 || cyc == 39) begin
            check_val({tag, " busy"}, {7'd0, busy}, 8'd1);
            check_val({tag, " done low"}, {7'd0, done}, 8'd0);
            check_val({tag, " pass low"}, {7'd0, pass}, 8'd0);
         end
         start = repulse && (cyc == 15);
         @(negedge clk);
      end
      start = 1'b0;
      check_val({tag, " end busy"}, {7'd0, busy}, 8'd0);
      check_val({tag, " end done"}, {7'd0, done}, 8'd1);
      check_val({tag, " end mask"}, {4'd0, err_mask}, {4'd0, exp_mask});
      check_val({tag, " end pass"}, {7'd0, pass}, {7'd0, exp_pass});
      check_val({tag, " end ab"}, {5'd0, a, b, vec_idx}, 8'd0);
   endtask

   // HOLD_CYCLES=2 sweep: y wrong on the first cycle of every vector, and on
   // the sampling cycle XORed with flip[k].
   task automatic sweep2(input string tag, input logic [3:0] flip, input logic [3:0] exp_mask,
                         input logic exp_pass);
      logic [3:0] tt;
      tt = 4'b0111;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check_val({tag, " busy"}, {7'd0, busy2}, 8'd1);
      for (int k = 0; k < 4; k++) begin
         y2 = ~tt[k];
         @(negedge clk);
         check_val({tag, " ab"}, {6'd0, a2, b2}, 8'(k));
         y2 = tt[k] ^ flip[k];
         @(negedge clk);
      end
      check_val({tag, " done"}, {7'd0, done2}, 8'd1);
      check_val({tag, " busy end"}, {7'd0, busy2}, 8'd0);
      check_val({tag, " mask"}, {4'd0, mask2}, {4'd0, exp_mask});
      check_val({tag, " pass"}, {7'd0, pass2}, {7'd0, exp_pass});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_val("reset ab/vec", {5'd0, a, b, vec_idx}, 8'd0);
      check_val("reset flags", {5'd0, busy, done, pass}, 8'd0);
      check_val("reset mask", {4'd0, err_mask}, 8'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle busy", {7'd0, busy}, 8'd0);

      gate_sel = 2'd0;
      pulse_start();
      sweep("nand", 4'b0000, 1'b1, 1'b0);

      gate_sel = 2'd1;
      pulse_start();
      sweep("and", 4'b1111, 1'b0, 1'b0);

      // Restart from DONE clears results on the accepting edge
      gate_sel = 2'd0;
      pulse_start();
      check_val("restart done", {7'd0, done}, 8'd0);
      check_val("restart mask", {4'd0, err_mask}, 8'd0);
      check_val("restart pass", {7'd0, pass}, 8'd0);
      sweep("restart+ignore", 4'b0000, 1'b1, 1'b1);

      gate_sel = 2'd2;
      pulse_start();
      sweep("fault11", 4'b1000, 1'b0, 1'b0);

      gate_sel = 2'd1;
      pulse_start();
      repeat (25) @(negedge clk);
      check_val("mid mask", {4'd0, err_mask}, 8'h03);
      check_val("mid ab", {6'd0, a, b}, 8'd2);
      rst_n = 1'b0;
      #1;
      check_val("async rst ab", {5'd0, a, b, vec_idx}, 8'd0);
      check_val("async rst flags", {5'd0, busy, done, pass}, 8'd0);
      check_val("async rst mask", {4'd0, err_mask}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post rst idle", {5'd0, busy, done, pass}, 8'd0);
      gate_sel = 2'd0;
      pulse_start();
      sweep("after rst", 4'b0000, 1'b1, 1'b0);

      sweep2("hold2 ok", 4'b0000, 4'b0000, 1'b1);
      sweep2("hold2 bad", 4'b0101, 4'b0101, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
